// File: rtl/pong_engine_if.sv
// pong_engine_if: player/command inputs and game status outputs of the pong engine
interface pong_engine_if;
    logic        tick;
    logic        start;
    logic        pause;
    logic        player_1_up;
    logic        player_1_down;
    logic        player_2_up;
    logic        player_2_down;
    logic [11:0] ball_x;
    logic [11:0] ball_y;
    logic [11:0] p1_y;
    logic [11:0] p2_y;
    logic [3:0]  score_1;
    logic [3:0]  score_2;
    logic [2:0]  game_state;
    logic [1:0]  winner;
    logic        point_pulse;

    modport master (
        output tick, start, pause, player_1_up, player_1_down, player_2_up, player_2_down,
        input  ball_x, ball_y, p1_y, p2_y, score_1, score_2, game_state, winner, point_pulse
    );

    modport slave (
        input  tick, start, pause, player_1_up, player_1_down, player_2_up, player_2_down,
        output ball_x, ball_y, p1_y, p2_y, score_1, score_2, game_state, winner, point_pulse
    );
endinterface

// File: rtl/pong_engine.sv
// pong_engine: two-player pong game engine; define PONG_AI_PLAYER2_EN to have the right paddle track the ball
module pong_engine #(
    parameter int FRAME_WIDTH     = 640,
    parameter int FRAME_HEIGHT    = 480,
    parameter int PADDLE_HEIGHT   = 60,
    parameter int PADDLE_WIDTH    = 8,
    parameter int PADDLE_X_OFFSET = 16,
    parameter int BALL_SIZE       = 8,
    parameter int PLAYER_SPEED    = 4,
    parameter int WIN_SCORE       = 7,
    parameter int SERVE_TICKS     = 60
) (
    input logic          CLOCK_25,
    input logic          reset,
    pong_engine_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        POINT  = 3'd4,
        OVER   = 3'd5
    } state_t;

    localparam logic signed [13:0] BX0       = 14'((FRAME_WIDTH - BALL_SIZE) / 2);
    localparam logic signed [13:0] BY0       = 14'((FRAME_HEIGHT - BALL_SIZE) / 2);
    localparam logic signed [13:0] PY0       = 14'((FRAME_HEIGHT - PADDLE_HEIGHT) / 2);
    localparam logic signed [13:0] PY_MAX    = 14'(FRAME_HEIGHT - PADDLE_HEIGHT);
    localparam logic signed [13:0] BX_MAX    = 14'(FRAME_WIDTH - BALL_SIZE);
    localparam logic signed [13:0] BY_MAX    = 14'(FRAME_HEIGHT - BALL_SIZE);
    localparam logic signed [13:0] P1_FACE   = 14'(PADDLE_X_OFFSET + PADDLE_WIDTH);
    localparam logic signed [13:0] P2_FACE   = 14'(FRAME_WIDTH - PADDLE_X_OFFSET - PADDLE_WIDTH - BALL_SIZE);
    localparam logic signed [13:0] BALL      = 14'(BALL_SIZE);
    localparam logic signed [13:0] HALF_BALL = 14'(BALL_SIZE / 2);
    localparam logic signed [13:0] PAD_H     = 14'(PADDLE_HEIGHT);
    localparam logic signed [13:0] HALF_PAD  = 14'(PADDLE_HEIGHT / 2);
    localparam logic signed [13:0] SPEED     = 14'(PLAYER_SPEED);
    localparam logic signed [13:0] Z1        = 14'(PADDLE_HEIGHT / 5);
    localparam logic signed [13:0] Z2        = 14'(2 * (PADDLE_HEIGHT / 5));
    localparam logic signed [13:0] Z3        = 14'(3 * (PADDLE_HEIGHT / 5));
    localparam logic signed [13:0] Z4        = 14'(4 * (PADDLE_HEIGHT / 5));
    localparam logic [3:0]         WIN       = 4'(WIN_SCORE);
    localparam logic [15:0]        SERVE_END = 16'(SERVE_TICKS - 1);

    state_t             state, state_n;
    logic [11:0]        bx, by, p1, p2, bx_n, by_n, p1_n, p2_n, p1m, p2m;
    logic signed [3:0]  dx, dy, dx_n, dy_n, zd, za, dyh;
    logic [3:0]         s1, s2, s1_n, s2_n;
    logic [1:0]         win, win_n;
    logic               pp, pp_n;
    logic [15:0]        cnt, cnt_n;
    logic signed [13:0] bxs, bys, p1s, p2s, nx, ny, yc;
    logic               top, bot, hit1, hit2;

    function automatic logic [11:0] clamp_pad(input logic signed [13:0] t);
        return (t < 14'sd0) ? 12'd0 : (t > PY_MAX) ? 12'(PY_MAX) : 12'(t);
    endfunction

    function automatic logic [11:0] move_pad(input logic signed [13:0] y, input logic up, input logic dn);
        return clamp_pad((up && !dn) ? y - SPEED : (dn && !up) ? y + SPEED : y);
    endfunction

    // Vertical speed from where the ball centre lands on the paddle, in fifths of its height
    function automatic logic signed [3:0] zone_dy(input logic signed [13:0] d);
        return (d >= Z4) ? 4'sd2 : (d >= Z3) ? 4'sd1 : (d >= Z2) ? 4'sd0 : (d >= Z1) ? -4'sd1 : -4'sd2;
    endfunction

    assign bxs = {2'b00, bx};
    assign bys = {2'b00, by};
    assign p1s = {2'b00, p1};
    assign p2s = {2'b00, p2};

    assign nx   = bxs + 14'(dx);
    assign ny   = bys + 14'(dy);
    assign top  = ny <= 14'sd0;
    assign bot  = ny >= BY_MAX;
    assign yc   = top ? 14'sd0 : bot ? BY_MAX : ny;
    assign hit1 = dx < 4'sd0 && nx <= P1_FACE && yc + BALL > p1s && yc < p1s + PAD_H;
    assign hit2 = dx > 4'sd0 && nx >= P2_FACE && yc + BALL > p2s && yc < p2s + PAD_H;
    assign zd   = zone_dy(yc + HALF_BALL - (hit1 ? p1s : p2s));
    assign za   = (zd == 4'sd0) ? 4'sd4 : (zd == 4'sd1 || zd == -4'sd1) ? 4'sd3 : 4'sd2;
    assign dyh  = (hit1 || hit2) ? zd : dy;

    assign p1m = move_pad(p1s, bus.player_1_up, bus.player_1_down);
`ifdef PONG_AI_PLAYER2_EN
    logic signed [13:0] gap;
    assign gap = (bys + HALF_BALL) - (p2s + HALF_PAD);
    assign p2m = clamp_pad(gap > SPEED ? p2s + SPEED : gap < -SPEED ? p2s - SPEED : p2s);
`else
    assign p2m = move_pad(p2s, bus.player_2_up, bus.player_2_down);
`endif

    // State register and game datapath; reset parks everything at the serve position
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bx    <= 12'(BX0);
            by    <= 12'(BY0);
            p1    <= 12'(PY0);
            p2    <= 12'(PY0);
            dx    <= 4'sd2;
            dy    <= 4'sd0;
            s1    <= 4'd0;
            s2    <= 4'd0;
            win   <= 2'b00;
            pp    <= 1'b0;
            cnt   <= 16'd0;
        end else begin
            state <= state_n;
            bx    <= bx_n;
            by    <= by_n;
            p1    <= p1_n;
            p2    <= p2_n;
            dx    <= dx_n;
            dy    <= dy_n;
            s1    <= s1_n;
            s2    <= s2_n;
            win   <= win_n;
            pp    <= pp_n;
            cnt   <= cnt_n;
        end
    end

    // Next state; commands win over a coincident tick, whose motion is then dropped
    always_comb begin
        state_n = state;
        bx_n    = bx;
        by_n    = by;
        p1_n    = p1;
        p2_n    = p2;
        dx_n    = dx;
        dy_n    = dy;
        s1_n    = s1;
        s2_n    = s2;
        win_n   = win;
        pp_n    = 1'b0;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus.start) state_n = SERVE;
            SERVE: if (bus.tick) begin
                p1_n    = p1m;
                p2_n    = p2m;
                cnt_n   = (cnt == SERVE_END) ? 16'd0 : cnt + 16'd1;
                state_n = (cnt == SERVE_END) ? PLAY : SERVE;
            end
            PLAY: if (bus.pause) begin
                state_n = PAUSED;
            end else if (bus.tick) begin
                p1_n = p1m;
                p2_n = p2m;
                by_n = 12'(yc);
                dy_n = (top || bot) ? -dyh : dyh;
                if (hit1) begin
                    bx_n = 12'(P1_FACE);
                    dx_n = za;
                end else if (hit2) begin
                    bx_n = 12'(P2_FACE);
                    dx_n = -za;
                end else if (nx <= 14'sd0) begin
                    bx_n    = 12'd0;
                    s2_n    = s2 + 4'd1;
                    pp_n    = 1'b1;
                    state_n = POINT;
                    dx_n    = -4'sd2;
                    dy_n    = 4'sd0;
                end else if (nx >= BX_MAX) begin
                    bx_n    = 12'(BX_MAX);
                    s1_n    = s1 + 4'd1;
                    pp_n    = 1'b1;
                    state_n = POINT;
                    dx_n    = 4'sd2;
                    dy_n    = 4'sd0;
                end else begin
                    bx_n = 12'(nx);
                end
            end
            PAUSED: if (bus.pause || bus.start) state_n = PLAY;
            POINT: if (bus.tick) begin
                if (s1 == WIN || s2 == WIN) begin
                    state_n = OVER;
                    win_n   = (s1 == WIN) ? 2'b01 : 2'b10;
                end else begin
                    state_n = SERVE;
                    bx_n    = 12'(BX0);
                    by_n    = 12'(BY0);
                end
            end
            OVER: if (bus.start) begin
                state_n = SERVE;
                s1_n    = 4'd0;
                s2_n    = 4'd0;
                win_n   = 2'b00;
                p1_n    = 12'(PY0);
                p2_n    = 12'(PY0);
                bx_n    = 12'(BX0);
                by_n    = 12'(BY0);
                dx_n    = 4'sd2;
                dy_n    = 4'sd0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ball_x      = bx;
    assign bus.ball_y      = by;
    assign bus.p1_y        = p1;
    assign bus.p2_y        = p2;
    assign bus.score_1     = s1;
    assign bus.score_2     = s2;
    assign bus.game_state  = state;
    assign bus.winner      = win;
    assign bus.point_pulse = pp;
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: scenario tasks plus random play checked against a behavioural game model
module tb_pong_engine;
    localparam int FW = 640, FH = 480, PH = 60, PW = 8, OFF = 16, BS = 8, SPD = 4, WIN = 7, ST = 60;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    pong_engine_if bus();
    pong_engine dut (.CLOCK_25(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [61:0] dut_vec;
    assign dut_vec = {bus.ball_x, bus.ball_y, bus.p1_y, bus.p2_y, bus.score_1, bus.score_2,
                      bus.game_state, bus.winner, bus.point_pulse};

    int m_st, m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_win, m_pp, m_cnt;
    int zdx[5] = '{2, 3, 4, 3, 2};
    int zdy[5] = '{-2, -1, 0, 1, 2};

    function automatic logic [61:0] exp_vec();
        return {12'(m_bx), 12'(m_by), 12'(m_p1), 12'(m_p2), 4'(m_s1), 4'(m_s2), 3'(m_st), 2'(m_win), 1'(m_pp)};
    endfunction

    function automatic int clamp_pad(input int y);
        return y < 0 ? 0 : y > FH - PH ? FH - PH : y;
    endfunction

    function automatic int pad_step(input int y, input bit up, input bit dn);
        return clamp_pad(y + ((up && !dn) ? -SPD : (dn && !up) ? SPD : 0));
    endfunction

    task automatic centre_ball();
        m_bx = (FW - BS) / 2;
        m_by = (FH - BS) / 2;
    endtask

    task automatic model_reset();
        m_st = 0; centre_ball();
        m_p1 = (FH - PH) / 2; m_p2 = (FH - PH) / 2;
        m_s1 = 0; m_s2 = 0; m_win = 0; m_pp = 0; m_dx = 2; m_dy = 0; m_cnt = 0;
    endtask

    task automatic move_paddles(input bit u1, input bit d1, input bit u2, input bit d2);
`ifdef PONG_AI_PLAYER2_EN
        int diff;
        diff = m_by + BS / 2 - (m_p2 + PH / 2);
        m_p2 = clamp_pad(m_p2 + (diff > SPD ? SPD : diff < -SPD ? -SPD : 0));
`else
        m_p2 = pad_step(m_p2, u2, d2);
`endif
        m_p1 = pad_step(m_p1, u1, d1);
    endtask

    task automatic score_point(input int serve_dx);
        m_pp = 1; m_st = 4; m_dx = serve_dx; m_dy = 0;
    endtask

    task automatic play_tick(input bit u1, input bit d1, input bit u2, input bit d2);
        int o1, o2, nx, ny, z, side;
        bit wall;
        o1 = m_p1; o2 = m_p2;
        move_paddles(u1, d1, u2, d2);
        nx = m_bx + m_dx; ny = m_by + m_dy; wall = 0; side = 0;
        if (ny <= 0) begin ny = 0; wall = 1; end
        else if (ny >= FH - BS) begin ny = FH - BS; wall = 1; end
        if (m_dx < 0 && nx <= OFF + PW && ny + BS > o1 && ny < o1 + PH) side = 1;
        if (m_dx > 0 && nx >= FW - OFF - PW - BS && ny + BS > o2 && ny < o2 + PH) side = 2;
        if (side != 0) begin
            z = (ny + BS / 2 - (side == 1 ? o1 : o2)) / (PH / 5);
            z = z < 0 ? 0 : z > 4 ? 4 : z;
            m_dy = zdy[z];
            m_dx = side == 1 ? zdx[z] : -zdx[z];
            nx = side == 1 ? OFF + PW : FW - OFF - PW - BS;
        end
        if (wall) m_dy = -m_dy;
        m_by = ny;
        if (side == 0 && nx <= 0) begin m_bx = 0; m_s2++; score_point(-2); end
        else if (side == 0 && nx >= FW - BS) begin m_bx = FW - BS; m_s1++; score_point(2); end
        else m_bx = nx;
    endtask

    task automatic model_step(input bit t, input bit s, input bit pa, input bit u1, input bit d1, input bit u2, input bit d2);
        m_pp = 0;
        case (m_st)
            0: if (s) m_st = 1;
            1: if (t) begin
                move_paddles(u1, d1, u2, d2);
                m_cnt++;
                if (m_cnt == ST) begin m_st = 2; m_cnt = 0; end
            end
            2: if (pa) m_st = 3; else if (t) play_tick(u1, d1, u2, d2);
            3: if (pa || s) m_st = 2;
            4: if (t) begin
                if (m_s1 == WIN || m_s2 == WIN) begin m_st = 5; m_win = m_s1 == WIN ? 1 : 2; end
                else begin m_st = 1; centre_ball(); end
            end
            5: if (s) begin model_reset(); m_st = 1; end
            default: ;
        endcase
    endtask

    task automatic step(input bit t, input bit s, input bit pa, input bit u1, input bit d1, input bit u2, input bit d2);
        bus.tick = t; bus.start = s; bus.pause = pa;
        bus.player_1_up = u1; bus.player_1_down = d1; bus.player_2_up = u2; bus.player_2_down = d2;
        @(posedge clk);
        model_step(t, s, pa, u1, d1, u2, d2);
        #1;
        bus.tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    endtask

    task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2);
        step(1, 0, 0, u1, d1, u2, d2);
        step(0, 0, 0, u1, d1, u2, d2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL reset_async: dut=%h model=%h", dut_vec, exp_vec()); end
        n_cmp++;
        if (bus.ball_x !== 12'd316 || bus.ball_y !== 12'd236 || bus.p1_y !== 12'd210 || bus.p2_y !== 12'd210) begin
            n_bad++; $display("FAIL reset_centre: got %0d,%0d,%0d,%0d want 316,236,210,210", bus.ball_x, bus.ball_y, bus.p1_y, bus.p2_y);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, i[0], 1, 0, 0, 1);
            n_cmp++;
            if (bus.game_state !== 3'd0 || dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL idle_hold: dut=%h model=%h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_serve();
        do_reset();
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= ST; i++) begin
            frame(0, 0, 0, 0);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL serve_tick%0d: dut=%h model=%h", i, dut_vec, exp_vec()); end
            if (i == ST - 1) begin
                n_cmp++;
                if (bus.game_state !== 3'd1) begin n_bad++; $display("FAIL serve_early: state=%0d want 1", bus.game_state); end
            end
        end
        n_cmp++;
        if (bus.game_state !== 3'd2) begin n_bad++; $display("FAIL serve_to_play: state=%0d want 2", bus.game_state); end
        frame(0, 0, 0, 0);
        n_cmp++;
        if (bus.ball_x !== 12'd318 || bus.ball_y !== 12'd236) begin
            n_bad++; $display("FAIL serve_first_move: got %0d,%0d want 318,236", bus.ball_x, bus.ball_y);
        end
    endtask

    task automatic test_rally();
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            frame(0, 0, 0, 0);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL rally_tick%0d: dut=%h model=%h", i, dut_vec, exp_vec()); end
            found = m_bx == OFF + PW && m_dx > 0;
        end
        n_cmp++;
        if (!found || bus.ball_x !== 12'd24) begin n_bad++; $display("FAIL p1_hit_face: ball_x=%0d want 24", bus.ball_x); end
        frame(0, 0, 0, 0);
        n_cmp++;
        if (bus.ball_x !== 12'd28 || bus.ball_y !== 12'd236) begin
            n_bad++; $display("FAIL p1_hit_centre_zone: got %0d,%0d want 28,236", bus.ball_x, bus.ball_y);
        end
    endtask

    task automatic test_pause();
        logic [61:0] frozen;
        frozen = dut_vec;
        step(1, 0, 1, 1, 0, 1, 0);
        n_cmp++;
        if (bus.game_state !== 3'd3 || dut_vec[61:14] !== frozen[61:14]) begin
            n_bad++; $display("FAIL pause_with_tick: dut=%h want positions %h state 3", dut_vec, frozen);
        end
        for (int i = 0; i < 100; i++) begin
            frame(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
            n_cmp++;
            if (dut_vec !== exp_vec() || dut_vec[61:14] !== frozen[61:14]) begin
                n_bad++; $display("FAIL paused_frozen%0d: dut=%h model=%h", i, dut_vec, exp_vec());
            end
        end
        step(0, 0, 1, 0, 0, 0, 0);
        frame(0, 0, 0, 0);
        n_cmp++;
        if (bus.game_state !== 3'd2 || bus.ball_x === frozen[61:50] || dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL pause_resume: dut=%h model=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_paddle_clamp();
        do_reset();
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 52; i++) frame(1, 0, 0, 1);
        n_cmp++;
        if (bus.p1_y !== 12'd2) begin n_bad++; $display("FAIL p1_before_top: p1_y=%0d want 2", bus.p1_y); end
        frame(1, 0, 0, 1);
        frame(1, 0, 0, 1);
        n_cmp++;
        if (bus.p1_y !== 12'd0) begin n_bad++; $display("FAIL p1_top_clamp: p1_y=%0d want 0", bus.p1_y); end
        for (int i = 0; i < 3; i++) frame(1, 1, 1, 1);
        n_cmp++;
        if (bus.p1_y !== 12'd0 || bus.p2_y !== 12'd420 || bus.game_state !== 3'd1) begin
            n_bad++; $display("FAIL both_buttons_hold: p1=%0d p2=%0d state=%0d want 0,420,1", bus.p1_y, bus.p2_y, bus.game_state);
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL clamp_model: dut=%h model=%h", dut_vec, exp_vec()); end
    endtask

    task automatic test_wall();
        bit found = 0;
        do_reset();
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) frame(0, 0, 0, 1);
        for (int i = 0; i < ST - 5; i++) frame(0, 0, 0, 0);
        for (int i = 0; i < 600 && !found; i++) begin
            frame(0, 0, 0, 0);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL wall_tick%0d: dut=%h model=%h", i, dut_vec, exp_vec()); end
            found = m_by == 0;
        end
        n_cmp++;
        if (!found || bus.ball_y !== 12'd0) begin n_bad++; $display("FAIL top_wall_clamp: ball_y=%0d want 0", bus.ball_y); end
        frame(0, 0, 0, 0);
        n_cmp++;
        if (bus.ball_y !== 12'd2) begin n_bad++; $display("FAIL top_wall_bounce: ball_y=%0d want 2", bus.ball_y); end
    endtask

    task automatic test_score_win();
        bit found = 0;
        logic [61:0] frozen;
        do_reset();
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2000 && !found; i++) begin
            step(1, 0, 0, 0, 0, 1, 0);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL win_run%0d: dut=%h model=%h", i, dut_vec, exp_vec()); end
            found = m_s1 == WIN;
            if (!found) step(0, 0, 0, 0, 0, 1, 0);
        end
        n_cmp++;
        if (!found || bus.score_1 !== 4'd7 || bus.point_pulse !== 1'b1 || bus.game_state !== 3'd4) begin
            n_bad++; $display("FAIL final_point: score_1=%0d pulse=%b state=%0d want 7,1,4", bus.score_1, bus.point_pulse, bus.game_state);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.point_pulse !== 1'b0) begin n_bad++; $display("FAIL pulse_width: point_pulse=%b want 0", bus.point_pulse); end
        frame(0, 0, 0, 0);
        n_cmp++;
        if (bus.game_state !== 3'd5 || bus.winner !== 2'b01) begin
            n_bad++; $display("FAIL game_over: state=%0d winner=%b want 5,01", bus.game_state, bus.winner);
        end
        frozen = dut_vec;
        for (int i = 0; i < 10; i++) frame(1, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (dut_vec !== frozen) begin n_bad++; $display("FAIL over_frozen: dut=%h want %h", dut_vec, frozen); end
        step(1, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.game_state !== 3'd1 || bus.score_1 !== 4'd0 || bus.winner !== 2'b00 || bus.p2_y !== 12'd210 || dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL over_restart: dut=%h model=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 2) == 0, ($urandom % 40) == 0, ($urandom % 25) == 0,
                 ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL random_cycle%0d: dut=%h model=%h", i, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_reset_mid();
        #3 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec !== exp_vec() || bus.game_state !== 3'd0) begin
            n_bad++; $display("FAIL reset_mid: dut=%h model=%h", dut_vec, exp_vec());
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.game_state !== 3'd1 || dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL reset_then_start: dut=%h model=%h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        bus.tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        bus.player_1_up = 1'b0; bus.player_1_down = 1'b0; bus.player_2_up = 1'b0; bus.player_2_down = 1'b0;
        model_reset();
        test_reset();
        test_serve();
        test_rally();
        test_pause();
        test_paddle_clamp();
        test_wall();
        test_score_win();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached after %0d comparisons", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
